// File: rtl/btb_assoc_array_pkg.sv
// Shared definitions for the set-associative BTB: counter constants, flush FSM
// encoding and small helper functions.
package btb_assoc_array_pkg;

   localparam logic [1:0] CTR_WEAK_T  = 2'b10;
   localparam logic [1:0] CTR_WEAK_NT = 2'b01;
   localparam logic [1:0] CTR_MAX     = 2'b11;
   localparam logic [1:0] CTR_MIN     = 2'b00;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } flush_state_e;

   // Saturating 2-bit direction counter step.
   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      if (taken) begin
         res = (ctr == CTR_MAX) ? ctr : ctr + 2'd1;
      end else begin
         res = (ctr == CTR_MIN) ? ctr : ctr - 2'd1;
      end
      return res;
   endfunction

   function automatic int plru_bits(input int ways);
      return (ways > 1) ? ways - 1 : 1;
   endfunction

endpackage

// File: rtl/btb_assoc_array_plru.sv
// Per-set tree pseudo-LRU state for 1, 2 or 4 ways. Two touch ports; the update
// port wins when both touch the same set.
module btb_assoc_array_plru
   import btb_assoc_array_pkg::*;
#(
   parameter int NUM_SETS = 8,
   parameter int NUM_WAYS = 2,
   parameter int IDX_W    = $clog2(NUM_SETS),
   parameter int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lk_touch,
   input  logic [IDX_W-1:0] lk_set,
   input  logic [WAY_W-1:0] lk_way,
   input  logic             up_touch,
   input  logic [IDX_W-1:0] up_set,
   input  logic [WAY_W-1:0] up_way,
   input  logic [IDX_W-1:0] vic_set,
   output logic [WAY_W-1:0] victim
);

   localparam int PLRU_W = plru_bits(NUM_WAYS);

   // Bit 0 is the root (0: evict left half); bits 1/2 choose within each pair.
   function automatic logic [PLRU_W-1:0] touch(input logic [PLRU_W-1:0] bits,
                                               input logic [WAY_W-1:0]  way);
      logic [2:0] t;
      logic [1:0] w;
      t = 3'(bits);
      w = 2'(way);
      if (NUM_WAYS == 4) begin
         t[0] = ~w[1];
         t[1] = w[1] ? t[1] : ~w[0];
         t[2] = w[1] ? ~w[0] : t[2];
      end else begin
         t[0] = ~w[0];
      end
      return PLRU_W'(t);
   endfunction

   function automatic logic [WAY_W-1:0] pick(input logic [PLRU_W-1:0] bits);
      logic [2:0] t;
      logic [1:0] v;
      t = 3'(bits);
      if (NUM_WAYS == 4) begin
         v = t[0] ? {1'b1, t[2]} : {1'b0, t[1]};
      end else begin
         v = {1'b0, t[0]};
      end
      return WAY_W'(v);
   endfunction

   generate
      if (NUM_WAYS == 1) begin : g_single
         logic unused_s;
         assign unused_s = ^{clk, rst, lk_touch, lk_set, lk_way, up_touch, up_set, up_way, vic_set};
         assign victim   = '0;
      end else begin : g_tree
         logic [PLRU_W-1:0] plru_q [NUM_SETS];
         logic [PLRU_W-1:0] plru_d [NUM_SETS];
         logic              lk_wins_s;

         assign lk_wins_s = lk_touch && !(up_touch && (up_set == lk_set));

         // Apply lookup touch first so a same-set update touch overrides it.
         always_comb begin
            plru_d         = plru_q;
            plru_d[lk_set] = lk_wins_s ? touch(plru_q[lk_set], lk_way) : plru_q[lk_set];
            plru_d[up_set] = up_touch ? touch(plru_q[up_set], up_way) : plru_d[up_set];
         end

         // PLRU state register.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int s = 0; s < NUM_SETS; s++) begin
                  plru_q[s] <= '0;
               end
            end else begin
               plru_q <= plru_d;
            end
         end

         assign victim = pick(plru_q[vic_set]);
      end
   endgenerate

endmodule

// File: rtl/btb_assoc_array.sv
// Set-associative branch target buffer: combinational lookup with update
// forwarding, counter training / allocation, and a one-set-per-cycle flush engine.
module btb_assoc_array
   import btb_assoc_array_pkg::*;
#(
   parameter int PC_W     = 32,
   parameter int NUM_SETS = 8,
   parameter int NUM_WAYS = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PC_W-1:0] lk_pc,
   input  logic            lk_en,
   output logic            lk_hit,
   output logic [PC_W-1:0] lk_target,
   output logic            lk_taken,
   input  logic            up_en,
   input  logic [PC_W-1:0] up_pc,
   input  logic [PC_W-1:0] up_target,
   input  logic            up_taken,
   input  logic            flush_req,
   output logic            busy,
   output logic            flush_done
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = PC_W - IDX_W - 2;
   localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(NUM_SETS - 1);

   logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
   logic [NUM_WAYS-1:0] valid_d  [NUM_SETS];
   logic [TAG_W-1:0]    tag_q    [NUM_SETS][NUM_WAYS];
   logic [TAG_W-1:0]    tag_d    [NUM_SETS][NUM_WAYS];
   logic [PC_W-1:0]     target_q [NUM_SETS][NUM_WAYS];
   logic [PC_W-1:0]     target_d [NUM_SETS][NUM_WAYS];
   logic [1:0]          ctr_q    [NUM_SETS][NUM_WAYS];
   logic [1:0]          ctr_d    [NUM_SETS][NUM_WAYS];

   flush_state_e        state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic                flush_clr_s, flush_done_s;

   logic [IDX_W-1:0]    lk_idx_s, up_idx_s;
   logic [TAG_W-1:0]    lk_tag_s, up_tag_s;
   logic                unused_s;

   logic [NUM_WAYS-1:0] up_match_s;
   logic                up_act_s, up_hit_s, inv_found_s;
   logic [WAY_W-1:0]    up_hit_way_s, inv_way_s, victim_s;
   logic                wr_en_s;
   logic [WAY_W-1:0]    wr_way_s;
   logic [PC_W-1:0]     wr_target_s;
   logic [1:0]          wr_ctr_s;

   logic                lk_ok_s;
   logic [NUM_WAYS-1:0] lk_match_s;
   logic                lk_hit_s, lk_taken_s;
   logic [WAY_W-1:0]    lk_way_s;
   logic [PC_W-1:0]     lk_target_s;

   assign lk_idx_s = lk_pc[IDX_W+1:2];
   assign lk_tag_s = lk_pc[PC_W-1:IDX_W+2];
   assign up_idx_s = up_pc[IDX_W+1:2];
   assign up_tag_s = up_pc[PC_W-1:IDX_W+2];
   assign unused_s = ^{lk_pc[1:0], up_pc[1:0]};

   // Flush sequencer: walks ptr over every set, then drops back to idle.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      flush_clr_s  = 1'b0;
      flush_done_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (flush_req) begin
               state_d = ST_FLUSH;
               ptr_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            flush_clr_s = 1'b1;
            if (ptr_q == PTR_LAST) begin
               state_d      = ST_IDLE;
               ptr_d        = '0;
               flush_done_s = 1'b1;
            end else begin
               ptr_d = ptr_q + IDX_W'(1'b1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   // Flush request in the same cycle takes priority over a pending update.
   assign up_act_s = up_en && (state_q == ST_IDLE) && !flush_req;

   // Update-side tag match, lowest invalid way, and the entry to be written.
   always_comb begin
      up_match_s   = '0;
      up_hit_s     = 1'b0;
      up_hit_way_s = '0;
      inv_found_s  = 1'b0;
      inv_way_s    = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         up_match_s[w] = valid_q[up_idx_s][w] && (tag_q[up_idx_s][w] == up_tag_s);
         up_hit_s      = up_hit_s | up_match_s[w];
         up_hit_way_s  = up_match_s[w] ? WAY_W'(w) : up_hit_way_s;
         inv_found_s   = inv_found_s | ~valid_q[up_idx_s][w];
         inv_way_s     = valid_q[up_idx_s][w] ? inv_way_s : WAY_W'(w);
      end
      wr_en_s     = up_act_s && (up_hit_s || up_taken);
      wr_way_s    = up_hit_s ? up_hit_way_s : (inv_found_s ? inv_way_s : victim_s);
      wr_target_s = (up_hit_s && !up_taken) ? target_q[up_idx_s][up_hit_way_s] : up_target;
      wr_ctr_s    = up_hit_s ? ctr_next(ctr_q[up_idx_s][up_hit_way_s], up_taken) : CTR_WEAK_T;
   end

   // Post-edge array contents; lookup reads these so a same-cycle write is visible.
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (wr_en_s) begin
         valid_d[up_idx_s][wr_way_s]  = 1'b1;
         tag_d[up_idx_s][wr_way_s]    = up_tag_s;
         target_d[up_idx_s][wr_way_s] = wr_target_s;
         ctr_d[up_idx_s][wr_way_s]    = wr_ctr_s;
      end else if (flush_clr_s) begin
         valid_d[ptr_q] = '0;
      end else begin
         valid_d[up_idx_s] = valid_q[up_idx_s];
      end
   end

   assign lk_ok_s = !rst && lk_en && (state_q == ST_IDLE);

   // Lookup tag compare; tags are unique per set so OR-reduction selects the hit way.
   always_comb begin
      lk_match_s  = '0;
      lk_hit_s    = 1'b0;
      lk_way_s    = '0;
      lk_target_s = '0;
      lk_taken_s  = 1'b0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         lk_match_s[w] = lk_ok_s && valid_d[lk_idx_s][w] && (tag_d[lk_idx_s][w] == lk_tag_s);
         lk_hit_s      = lk_hit_s | lk_match_s[w];
         lk_way_s      = lk_match_s[w] ? WAY_W'(w) : lk_way_s;
         lk_target_s   = lk_target_s | (lk_match_s[w] ? target_d[lk_idx_s][w] : '0);
         lk_taken_s    = lk_taken_s | (lk_match_s[w] & ctr_d[lk_idx_s][w][1]);
      end
   end

   // Entry arrays and flush FSM state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
               tag_q[s][w]    <= '0;
               target_q[s][w] <= '0;
               ctr_q[s][w]    <= CTR_WEAK_NT;
            end
         end
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         ctr_q    <= ctr_d;
      end
   end

   btb_assoc_array_plru #(
      .NUM_SETS (NUM_SETS),
      .NUM_WAYS (NUM_WAYS),
      .IDX_W    (IDX_W),
      .WAY_W    (WAY_W)
   ) u_plru (
      .clk      (clk),
      .rst      (rst),
      .lk_touch (lk_hit_s),
      .lk_set   (lk_idx_s),
      .lk_way   (lk_way_s),
      .up_touch (wr_en_s),
      .up_set   (up_idx_s),
      .up_way   (wr_way_s),
      .vic_set  (up_idx_s),
      .victim   (victim_s)
   );

   assign lk_hit     = lk_hit_s;
   assign lk_target  = lk_target_s;
   assign lk_taken   = lk_taken_s;
   assign busy       = (state_q == ST_FLUSH);
   assign flush_done = flush_done_s;

endmodule

// File: tb/tb_btb_assoc_array.sv
// Randomised and directed bench for btb_assoc_array (8 sets, 2 ways) against an
// LRU-based behavioural model of the buffer.
module tb_btb_assoc_array;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] lk_pc, up_pc, up_target, lk_target;
   logic        lk_en, lk_hit, lk_taken, up_en, up_taken, flush_req, busy, flush_done;

   int n_checks = 0;
   int n_errors = 0;

   bit          m_valid [8][2];
   int unsigned m_tag   [8][2];
   logic [31:0] m_tgt   [8][2];
   int          m_ctr   [8][2];
   int          m_mru   [8];
   int          fl_ptr;

   logic        obs_hit, obs_taken, obs_busy, obs_done;
   logic [31:0] obs_tgt;
   int          cnt_busy, cnt_done;

   btb_assoc_array #(.PC_W(32), .NUM_SETS(8), .NUM_WAYS(2)) dut (
      .clk(clk), .rst(rst), .lk_pc(lk_pc), .lk_en(lk_en), .lk_hit(lk_hit),
      .lk_target(lk_target), .lk_taken(lk_taken), .up_en(up_en), .up_pc(up_pc),
      .up_target(up_target), .up_taken(up_taken), .flush_req(flush_req),
      .busy(busy), .flush_done(flush_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 8; s++) begin
         m_mru[s] = 1;  // victim way 0 first
         for (int w = 0; w < 2; w++) begin
            m_valid[s][w] = 1'b0;
            m_tag[s][w]   = 0;
            m_tgt[s][w]   = 32'h0;
            m_ctr[s][w]   = 1;
         end
      end
      fl_ptr = -1;
   endtask

   // One clock cycle: drive inputs, predict outputs from the model, compare at negedge.
   task automatic cycle(input bit le, input logic [31:0] lpc, input bit ue,
                        input logic [31:0] upc, input logic [31:0] ut, input bit utk,
                        input bit fr);
      int li, ui, hw, upd_way;
      bit e_hit, e_tk, e_busy, e_done;
      logic [31:0] e_tgt;
      lk_en = le; lk_pc = lpc; up_en = ue; up_pc = upc;
      up_target = ut; up_taken = utk; flush_req = fr;
      @(negedge clk);
      li = (lpc >> 2) % 8;
      ui = (upc >> 2) % 8;
      e_busy = (fl_ptr >= 0);
      e_done = (fl_ptr == 7);
      upd_way = -1;
      if (e_busy) begin
         m_valid[fl_ptr][0] = 1'b0;
         m_valid[fl_ptr][1] = 1'b0;
         fl_ptr = (fl_ptr == 7) ? -1 : fl_ptr + 1;
      end else if (fr) begin
         fl_ptr = 0;
      end else if (ue) begin
         hw = -1;
         for (int w = 0; w < 2; w++)
            if (m_valid[ui][w] && m_tag[ui][w] == (upc >> 5)) hw = w;
         if (hw >= 0) begin
            m_ctr[ui][hw] = utk ? ((m_ctr[ui][hw] == 3) ? 3 : m_ctr[ui][hw] + 1)
                                : ((m_ctr[ui][hw] == 0) ? 0 : m_ctr[ui][hw] - 1);
            if (utk) m_tgt[ui][hw] = ut;
            upd_way = hw;
         end else if (utk) begin
            for (int w = 1; w >= 0; w--)
               if (!m_valid[ui][w]) upd_way = w;
            if (upd_way < 0) upd_way = 1 - m_mru[ui];
            m_valid[ui][upd_way] = 1'b1;
            m_tag[ui][upd_way]   = upc >> 5;
            m_tgt[ui][upd_way]   = ut;
            m_ctr[ui][upd_way]   = 2;
         end
      end
      e_hit = 1'b0; e_tk = 1'b0; e_tgt = 32'h0;
      if (le && !e_busy) begin
         for (int w = 0; w < 2; w++) begin
            if (m_valid[li][w] && m_tag[li][w] == (lpc >> 5)) begin
               e_hit = 1'b1;
               e_tgt = m_tgt[li][w];
               e_tk  = (m_ctr[li][w] >= 2);
               m_mru[li] = w;
            end
         end
      end
      if (upd_way >= 0) m_mru[ui] = upd_way;
      obs_hit = lk_hit; obs_tgt = lk_target; obs_taken = lk_taken;
      obs_busy = busy; obs_done = flush_done;
      check_eq("lk_hit", lk_hit, e_hit);
      check_eq("lk_target", lk_target, e_tgt);
      check_eq("lk_taken", lk_taken, e_tk);
      check_eq("busy", busy, e_busy);
      check_eq("flush_done", flush_done, e_done);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rnd_pc();
      logic [26:0] t;
      logic [2:0]  i;
      logic [1:0]  b;
      t = 27'($urandom_range(128, 132));
      i = 3'($urandom_range(0, 7));
      b = 2'($urandom);
      return {t, i, b};
   endfunction

   initial begin
      logic [31:0] a, l;
      rst = 1'b1; lk_en = 1'b1; lk_pc = 32'h0000_1000; up_en = 1'b0; up_pc = 32'h0;
      up_target = 32'h0; up_taken = 1'b0; flush_req = 1'b0;
      model_reset();
      #12;
      check_eq("rst_hit", lk_hit, 32'd0);
      check_eq("rst_target", lk_target, 32'h0);
      check_eq("rst_busy", busy, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: empty lookup
      cycle(1'b1, 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check_eq("t1_hit", obs_hit, 32'd0);
      // 2: allocate with same-cycle forwarding, then plain hit
      cycle(1'b1, 32'h1000, 1'b1, 32'h1000, 32'h2000, 1'b1, 1'b0);
      check_eq("t2_fwd_hit", obs_hit, 32'd1);
      check_eq("t2_fwd_tgt", obs_tgt, 32'h2000);
      cycle(1'b1, 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check_eq("t2_hit", obs_hit, 32'd1);
      check_eq("t2_tk", obs_taken, 32'd1);
      // 3: counter saturates low, one taken step stays weakly not-taken
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'h1000, 1'b1, 32'h1000, 32'h0, 1'b0, 1'b0);
      check_eq("t3_nt", obs_taken, 32'd0);
      cycle(1'b1, 32'h1000, 1'b1, 32'h1000, 32'h2000, 1'b1, 1'b0);
      check_eq("t3_tk", obs_taken, 32'd0);
      check_eq("t3_hit", obs_hit, 32'd1);
      // 4: replacement in set 0
      cycle(1'b0, 32'h0, 1'b1, 32'h1000, 32'h2000, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 32'h1020, 32'h3020, 1'b1, 1'b0);
      cycle(1'b1, 32'h1020, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 32'h1040, 32'h3040, 1'b1, 1'b0);
      cycle(1'b1, 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check_eq("t4_evict", obs_hit, 32'd0);
      cycle(1'b1, 32'h1020, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check_eq("t4_keep", obs_hit, 32'd1);
      cycle(1'b1, 32'h1040, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check_eq("t4_new", obs_hit, 32'd1);
      check_eq("t4_tgt", obs_tgt, 32'h3040);
      // 5: fill, flush with updates attempted mid-flush
      for (int s = 0; s < 8; s++)
         cycle(1'b0, 32'h0, 1'b1, 32'h3000 + 32'(s * 4), 32'h5000 + 32'(s), 1'b1, 1'b0);
      cnt_busy = 0; cnt_done = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 32'h3000, 1'b1, 32'h3000 + 32'(i * 4), 32'h6000, 1'b1, (i < 3));
         cnt_busy += obs_busy; cnt_done += obs_done;
      end
      check_eq("t5_busy_cycles", cnt_busy, 32'd8);
      check_eq("t5_done_pulses", cnt_done, 32'd1);
      for (int s = 1; s < 8; s++)
         cycle(1'b1, 32'h3000 + 32'(s * 4), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check_eq("t5_miss", obs_hit, 32'd0);
      // 6: reset in the middle of a flush
      cycle(1'b0, 32'h0, 1'b1, 32'h1000, 32'h2000, 1'b1, 1'b0);
      cycle(1'b1, 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      cycle(1'b1, 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      cycle(1'b1, 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check_eq("t6_busy", busy, 32'd0);
      check_eq("t6_done", flush_done, 32'd0);
      check_eq("t6_hit", lk_hit, 32'd0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      cycle(1'b1, 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check_eq("t6_cleared", obs_hit, 32'd0);
      cnt_busy = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, (i == 0));
         cnt_busy += obs_busy;
      end
      check_eq("t6_busy_cycles", cnt_busy, 32'd8);

      // Random traffic over a small pool of tags so sets conflict often.
      for (int i = 0; i < 600; i++) begin
         a = rnd_pc();
         l = ($urandom_range(0, 3) == 0) ? a : rnd_pc();
         cycle($urandom_range(0, 3) != 0, l, $urandom_range(0, 1) == 1, a, $urandom,
               $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
